// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD digit collector and the downstream BCD-to-binary converter.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } coll_state_t;

endpackage

// File: rtl/bcd_digit_collector.sv
// Collects decimal digits calculator-style into a packed BCD word. Build option: BCD_DIGIT_CHECK_EN.
// Latency: word offered 1 cycle after the last digit is accepted or after an early commit.
// Backpressure: digit_ready drops while a word is offered; the word holds until bcd_ready.
module bcd_digit_collector
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [3:0]                        digit,
    input  logic                              digit_valid,
    output logic                              digit_ready,
    input  logic                              commit,
    input  logic                              clear,
    output logic [4*NUM_DIGITS-1:0]           bcd_out,
    output logic                              bcd_valid,
    input  logic                              bcd_ready,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic                              err_digit
);

    localparam int W     = BCD_DIGIT_W * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    coll_state_t      state_q, state_nxt;
    logic [W-1:0]     shreg_q, shreg_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             err_q, err_nxt;
    logic             accept, digit_legal, store;

    assign accept = digit_valid && digit_ready;

`ifdef BCD_DIGIT_CHECK_EN
    // Illegal digits still complete the handshake so the keypad side never stalls.
    assign digit_legal = (digit <= BCD_MAX_DIGIT);
    assign err_nxt     = accept && !digit_legal;
`else
    assign digit_legal = 1'b1;
    assign err_nxt     = 1'b0;
`endif

    assign store = accept && digit_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            shreg_q <= shreg_nxt;
            cnt_q   <= cnt_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        shreg_nxt = shreg_q;
        cnt_nxt   = cnt_q;
        unique case (state_q)
            IDLE, COLLECT: begin
                if (clear) begin
                    state_nxt = IDLE;
                    shreg_nxt = '0;
                    cnt_nxt   = '0;
                end else begin
                    if (store) begin
                        // Truncating cast drops the oldest digit slot; avoids a negative slice when NUM_DIGITS is 1.
                        shreg_nxt = W'({shreg_q, digit});
                        cnt_nxt   = cnt_q + CNT_W'(1);
                    end
                    if (cnt_nxt == CNT_W'(NUM_DIGITS))
                        state_nxt = HOLD;
                    else if (cnt_nxt != '0 && commit)
                        state_nxt = HOLD;
                    else if (cnt_nxt != '0)
                        state_nxt = COLLECT;
                    else
                        state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (bcd_ready) begin
                    state_nxt = IDLE;
                    shreg_nxt = '0;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                shreg_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        digit_ready = (state_q != HOLD);
        bcd_valid   = (state_q == HOLD);
    end

    assign bcd_out     = shreg_q;
    assign digit_count = cnt_q;
    assign err_digit   = err_q;

endmodule

// File: tb/tb_bcd_digit_collector.sv
// Directed bench for bcd_digit_collector; expected values are hand-computed per vector.
module tb_bcd_digit_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        digit_valid = 1'b0;
    logic        digit_ready;
    logic        commit = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] bcd_out;
    logic        bcd_valid;
    logic        bcd_ready = 1'b0;
    logic [2:0]  digit_count;
    logic        err_digit;

    int checks = 0;
    int failures = 0;

    bcd_digit_collector #(.NUM_DIGITS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .commit      (commit),
        .clear       (clear),
        .bcd_out     (bcd_out),
        .bcd_valid   (bcd_valid),
        .bcd_ready   (bcd_ready),
        .digit_count (digit_count),
        .err_digit   (err_digit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic cmt);
        digit       = d;
        digit_valid = 1'b1;
        commit      = cmt;
        tick();
        digit_valid = 1'b0;
        commit      = 1'b0;
    endtask

    task automatic drain();
        bcd_ready = 1'b1;
        tick();
        bcd_ready = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_valid", bcd_valid, 0);
        chk("rst_out", bcd_out, 0);
        chk("rst_count", digit_count, 0);
        chk("rst_ready", digit_ready, 1);
        chk("rst_err", err_digit, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Full word with auto-commit, downstream always ready.
        bcd_ready = 1'b1;
        send(4'd1, 1'b0);
        chk("t1_cnt1", digit_count, 1);
        chk("t1_out1", bcd_out, 16'h0001);
        send(4'd2, 1'b0);
        send(4'd3, 1'b0);
        chk("t1_cnt3", digit_count, 3);
        chk("t1_valid_early", bcd_valid, 0);
        send(4'd4, 1'b0);
        chk("t1_valid", bcd_valid, 1);
        chk("t1_out", bcd_out, 16'h1234);
        chk("t1_ready_hold", digit_ready, 0);
        tick();
        chk("t1_valid_after", bcd_valid, 0);
        chk("t1_cnt_after", digit_count, 0);
        chk("t1_ready_after", digit_ready, 1);
        bcd_ready = 1'b0;

        // Early commit after two digits.
        send(4'd4, 1'b0);
        send(4'd2, 1'b0);
        chk("t2_valid_pre", bcd_valid, 0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("t2_valid", bcd_valid, 1);
        chk("t2_out", bcd_out, 16'h0042);
        chk("t2_cnt", digit_count, 2);
        drain();
        chk("t2_released", bcd_valid, 0);

        // Backpressure with digit_valid held high; a clear while holding is ignored.
        digit = 4'd9;
        digit_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t3_valid", bcd_valid, 1);
        for (int i = 0; i < 5; i++) begin
            clear = (i == 2);
            tick();
            chk("t3_ready_low", digit_ready, 0);
            chk("t3_out_stable", bcd_out, 16'h9999);
            chk("t3_cnt_stable", digit_count, 4);
        end
        clear = 1'b0;
        digit_valid = 1'b0;
        drain();
        chk("t3_released", bcd_valid, 0);
        chk("t3_cnt_zero", digit_count, 0);
        chk("t3_out_zero", bcd_out, 0);

        // Clear wins over a simultaneous digit.
        send(4'd7, 1'b0);
        send(4'd5, 1'b0);
        chk("t4_partial", bcd_out, 16'h0075);
        clear = 1'b1;
        send(4'd3, 1'b0);
        clear = 1'b0;
        chk("t4_cnt", digit_count, 0);
        chk("t4_out", bcd_out, 0);
        chk("t4_idle", digit_ready, 1);
        chk("t4_novalid", bcd_valid, 0);
        send(4'd8, 1'b1);
        chk("t4_commit_valid", bcd_valid, 1);
        chk("t4_commit_out", bcd_out, 16'h0008);
        drain();

        // Illegal digit handling.
        send(4'd3, 1'b0);
        send(4'hC, 1'b0);
`ifdef BCD_DIGIT_CHECK_EN
        chk("t5_err", err_digit, 1);
        chk("t5_cnt_err", digit_count, 1);
`else
        chk("t5_err", err_digit, 0);
        chk("t5_cnt_err", digit_count, 2);
`endif
        send(4'd6, 1'b0);
        chk("t5_err_clear", err_digit, 0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("t5_valid", bcd_valid, 1);
`ifdef BCD_DIGIT_CHECK_EN
        chk("t5_out", bcd_out, 16'h0036);
`else
        chk("t5_out", bcd_out, 16'h03C6);
`endif
        drain();

        // Asynchronous reset while a word is offered, then commit in IDLE.
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        send(4'd3, 1'b0);
        send(4'd4, 1'b0);
        chk("t6_hold", bcd_out, 16'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", bcd_valid, 0);
        chk("t6_async_out", bcd_out, 0);
        chk("t6_async_cnt", digit_count, 0);
        tick();
        rst_n = 1'b1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("t6_idle_commit", bcd_valid, 0);
        chk("t6_idle_ready", digit_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
